// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store control stage.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] PH_REQ  = 2'd0;
  localparam logic [1:0] PH_WB   = 2'd1;
  localparam logic [1:0] PH_WAIT = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_REQ  = 2'd1,
    LD_WAIT = 2'd2,
    LD_WB   = 2'd3
  } lsu_state_e;

  // Halfword at offset 3 or word at any nonzero offset.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (((f3 == F3_H) || (f3 == F3_HU)) && (off == 2'd3)) ||
           ((f3 == F3_W) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane select and sign/zero extension; offset 0 is the most significant byte.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      func3,
  output logic [XLEN-1:0] load_data
);

  logic [XLEN-1:0] shifted;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic            half_tail;

  always_comb begin
    shifted   = rdata << {offset, 3'b000};
    byte_v    = shifted[XLEN-1 -: 8];
    half_v    = shifted[XLEN-1 -: 16];
    // A halfword at offset 3 runs off the word; only the last byte is returned.
    half_tail = (offset == 2'd3);
    case (func3)
      F3_B:    load_data = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, byte_v};
      F3_H:    load_data = half_tail ? {{(XLEN-8){rdata[7]}}, rdata[7:0]}
                                     : {{(XLEN-16){half_v[15]}}, half_v};
      F3_HU:   load_data = half_tail ? {{(XLEN-8){1'b0}}, rdata[7:0]}
                                     : {{(XLEN-16){1'b0}}, half_v};
      F3_W:    load_data = rdata;
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control: sequences multi-cycle loads, drives data memory, aligns load data.
// Optional sticky misalignment flag enabled by LSU_MISALIGN_TRAP_EN.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            is_lw,
  input  logic [3:0]      mem_write,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] data_addr,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] dm_rdata,
  output logic [1:0]      counter02,
  output logic            stall,
  output logic            dm_en,
  output logic [3:0]      dm_web,
  output logic [XLEN-1:0] dm_addr,
  output logic [XLEN-1:0] dm_wdata,
  output logic [XLEN-1:0] load_data,
  output logic            load_valid
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic            misalign
`endif
);

  localparam logic [1:0] WAIT_LAST = (MEM_WAIT > 0) ? 2'(MEM_WAIT - 1) : 2'd0;

  lsu_state_e      state_q, state_d;
  logic [1:0]      wait_cnt_q, wait_cnt_d;
  logic [1:0]      off_q, off_d;
  logic [2:0]      f3_q, f3_d;
  logic            access_mis;
  logic            ld_zero;
  logic [XLEN-1:0] aligned;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    off_d      = off_q;
    f3_d       = f3_q;
    counter02  = PH_REQ;
    stall      = 1'b0;
    dm_en      = 1'b0;
    dm_web     = 4'b0000;
    load_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_lw) begin
          // This cycle is the load request phase.
          dm_en      = 1'b1;
          stall      = 1'b1;
          off_d      = data_addr[1:0];
          f3_d       = func3;
          wait_cnt_d = 2'd0;
          state_d    = (MEM_WAIT > 0) ? LD_WAIT : LD_WB;
        end else begin
          dm_web = access_mis ? 4'b0000 : mem_write;
        end
      end
      LD_WAIT: begin
        counter02 = PH_WAIT;
        stall     = 1'b1;
        if (wait_cnt_q == WAIT_LAST) state_d = LD_WB;
        else                         wait_cnt_d = wait_cnt_q + 2'd1;
      end
      LD_WB: begin
        counter02  = PH_WB;
        load_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= 2'd0;
      off_q      <= 2'd0;
      f3_q       <= F3_B;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      off_q      <= off_d;
      f3_q       <= f3_d;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  logic mis_ld_q, mis_ld_d;

  assign access_mis = is_misaligned(func3, data_addr[1:0]);

  always_comb begin
    misalign_d = misalign_q;
    mis_ld_d   = mis_ld_q;
    if (state_q == IDLE) begin
      if (is_lw) mis_ld_d = access_mis;
      if ((is_lw || (mem_write != 4'b0000)) && access_mis) misalign_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
      mis_ld_q   <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
      mis_ld_q   <= mis_ld_d;
    end
  end

  assign misalign = misalign_q;
  assign ld_zero  = mis_ld_q;
`else
  assign access_mis = 1'b0;
  assign ld_zero    = 1'b0;
`endif

  always_comb begin
    case (func3)
      F3_B:    dm_wdata = {(XLEN/8){rs2_data[7:0]}};
      F3_H:    dm_wdata = {(XLEN/16){rs2_data[15:0]}};
      default: dm_wdata = rs2_data;
    endcase
  end

  assign dm_addr = {data_addr[XLEN-1:2], 2'b00};

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .rdata     (dm_rdata),
    .offset    (off_q),
    .func3     (f3_q),
    .load_data (aligned)
  );

  assign load_data = (load_valid && !ld_zero) ? aligned : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench: one DUT with MEM_WAIT=0 and one with MEM_WAIT=2 share stimulus.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_lw;
  logic [3:0]  mem_write;
  logic [2:0]  func3;
  logic [31:0] data_addr, rs2_data, dm_rdata;

  logic [1:0]  cnt0, cnt2;
  logic        stall0, stall2, en0, en2, lv0, lv2;
  logic [3:0]  web0, web2;
  logic [31:0] addr0, addr2, wdata0, wdata2, ld0, ld2;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        mis0, mis2;
`endif

  int checks = 0;
  int failures = 0;

  logic [1:0]  o_cnt;
  logic        o_stall, o_en, o_lv;
  logic [3:0]  o_web;
  logic [31:0] o_ld;

  always #5 clk = ~clk;

  lsu_ctrl #(.MEM_WAIT(0), .XLEN(32)) u_dut0 (
    .clk(clk), .rst(rst), .is_lw(is_lw), .mem_write(mem_write), .func3(func3),
    .data_addr(data_addr), .rs2_data(rs2_data), .dm_rdata(dm_rdata),
    .counter02(cnt0), .stall(stall0), .dm_en(en0), .dm_web(web0), .dm_addr(addr0),
    .dm_wdata(wdata0), .load_data(ld0), .load_valid(lv0)
`ifdef LSU_MISALIGN_TRAP_EN
    , .misalign(mis0)
`endif
  );

  lsu_ctrl #(.MEM_WAIT(2), .XLEN(32)) u_dut2 (
    .clk(clk), .rst(rst), .is_lw(is_lw), .mem_write(mem_write), .func3(func3),
    .data_addr(data_addr), .rs2_data(rs2_data), .dm_rdata(dm_rdata),
    .counter02(cnt2), .stall(stall2), .dm_en(en2), .dm_web(web2), .dm_addr(addr2),
    .dm_wdata(wdata2), .load_data(ld2), .load_valid(lv2)
`ifdef LSU_MISALIGN_TRAP_EN
    , .misalign(mis2)
`endif
  );

  function automatic logic mis_ref(input logic [1:0] off, input logic [2:0] f3);
`ifdef LSU_MISALIGN_TRAP_EN
    return ((f3 == 3'b001 || f3 == 3'b101) && off == 2'd3) || (f3 == 3'b010 && off != 2'd0);
`else
    return 1'b0;
`endif
  endfunction

  // Reference: memory word as four bytes, byte 0 most significant.
  function automatic logic [31:0] load_ref(input logic [31:0] rd, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [7:0]  b [4];
    logic [15:0] h;
    int o;
    for (int i = 0; i < 4; i++) b[i] = rd[31-8*i -: 8];
    o = int'(off);
    if (mis_ref(off, f3)) return 32'h0;
    case (f3)
      3'b000: return int'($signed(b[o]));
      3'b100: return {24'h0, b[o]};
      3'b001, 3'b101: begin
        if (o == 3) return (f3 == 3'b001) ? int'($signed(b[3])) : {24'h0, b[3]};
        h = {b[o], b[o+1]};
        return (f3 == 3'b001) ? int'($signed(h)) : {16'h0, h};
      end
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] store_ref(input logic [31:0] v, input logic [2:0] f3);
    if (f3 == 3'b000) return {v[7:0], v[7:0], v[7:0], v[7:0]};
    if (f3 == 3'b001) return {v[15:0], v[15:0]};
    return v;
  endfunction

  task automatic sample(input int w);
    if (w == 0) begin
      o_cnt = cnt0; o_stall = stall0; o_en = en0; o_web = web0; o_ld = ld0; o_lv = lv0;
    end else begin
      o_cnt = cnt2; o_stall = stall2; o_en = en2; o_web = web2; o_ld = ld2; o_lv = lv2;
    end
  endtask

  task automatic idle(input int n);
    is_lw = 1'b0; mem_write = 4'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered 1 time unit after a rising edge with the DUT in IDLE; leaves it there.
  task automatic do_load(input int w, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] rdata);
    logic [31:0] exp;
    int nwait;
    exp   = load_ref(rdata, addr[1:0], f3);
    nwait = (w == 0) ? 0 : 2;
    is_lw = 1'b1; mem_write = 4'b0; data_addr = addr; func3 = f3; dm_rdata = $urandom;
    #1; sample(w);
    checks++;
    if (o_cnt !== 2'd0 || o_stall !== 1'b1 || o_en !== 1'b1 || o_lv !== 1'b0 || o_web !== 4'b0) begin
      failures++;
      $display("FAIL load_req w=%0d cnt=%0d stall=%b en=%b lv=%b web=%b (want 0 1 1 0 0000)",
               w, o_cnt, o_stall, o_en, o_lv, o_web);
    end
    @(posedge clk); #1;
    is_lw = 1'($urandom); data_addr = $urandom; func3 = 3'($urandom);
    mem_write = 4'($urandom); dm_rdata = rdata;
    for (int i = 0; i < nwait; i++) begin
      #1; sample(w);
      checks++;
      if (o_cnt !== 2'd2 || o_stall !== 1'b1 || o_en !== 1'b0 || o_lv !== 1'b0 || o_web !== 4'b0) begin
        failures++;
        $display("FAIL load_wait w=%0d i=%0d cnt=%0d stall=%b en=%b lv=%b web=%b (want 2 1 0 0 0000)",
                 w, i, o_cnt, o_stall, o_en, o_lv, o_web);
      end
      @(posedge clk); #1;
    end
    #1; sample(w);
    checks++;
    if (o_cnt !== 2'd1 || o_stall !== 1'b0 || o_lv !== 1'b1 || o_en !== 1'b0 ||
        o_web !== 4'b0 || o_ld !== exp) begin
      failures++;
      $display("FAIL load_wb w=%0d f3=%0d addr=%h rd=%h cnt=%0d stall=%b lv=%b en=%b web=%b data=%h want data=%h",
               w, f3, addr, rdata, o_cnt, o_stall, o_lv, o_en, o_web, o_ld, exp);
    end
    is_lw = 1'b0; mem_write = 4'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; is_lw = 1'b0; mem_write = 4'b0; func3 = 3'b0;
    data_addr = 32'h0; rs2_data = 32'h0; dm_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cnt0 !== 2'd0 || stall0 !== 1'b0 || en0 !== 1'b0 || lv0 !== 1'b0 || ld0 !== 32'h0 ||
        cnt2 !== 2'd0 || stall2 !== 1'b0 || en2 !== 1'b0 || lv2 !== 1'b0 || ld2 !== 32'h0) begin
      failures++;
      $display("FAIL reset_state cnt=%0d/%0d stall=%b/%b en=%b/%b lv=%b/%b ld=%h/%h (want all 0)",
               cnt0, cnt2, stall0, stall2, en0, en2, lv0, lv2, ld0, ld2);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    logic [2:0]  f3;
    logic [3:0]  exp_web;
    is_lw = 1'b0; func3 = 3'b010; data_addr = 32'h10; rs2_data = 32'hDEADBEEF; mem_write = 4'hF;
    #1;
    checks++;
    if (web0 !== 4'hF || wdata0 !== 32'hDEADBEEF || addr0 !== 32'h10 || stall0 !== 1'b0) begin
      failures++;
      $display("FAIL store_sw web=%b wdata=%h addr=%h stall=%b want 1111 deadbeef 00000010 0",
               web0, wdata0, addr0, stall0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      f3 = 3'(i % 3);
      func3 = f3; data_addr = $urandom; rs2_data = $urandom; mem_write = 4'($urandom_range(1, 15));
      exp_web = mis_ref(data_addr[1:0], f3) ? 4'b0 : mem_write;
      #1;
      checks++;
      if (web0 !== exp_web || web2 !== exp_web || wdata0 !== store_ref(rs2_data, f3) ||
          addr0 !== {data_addr[31:2], 2'b00} || stall0 !== 1'b0 || cnt0 !== 2'd0 || en0 !== 1'b0) begin
        failures++;
        $display("FAIL store_rand f3=%0d addr=%h web=%b/%b wdata=%h addr_o=%h stall=%b want web=%b wdata=%h",
                 f3, data_addr, web0, web2, wdata0, addr0, stall0, exp_web, store_ref(rs2_data, f3));
      end
      @(posedge clk); #1;
    end
    idle(1);
  endtask

  task automatic test_load_directed();
    do_load(0, 32'h21, 3'b000, 32'h1280FF34);
    idle(4);
    do_load(0, 32'h22, 3'b101, 32'hAAAA8001);
    idle(4);
    do_load(0, 32'h22, 3'b001, 32'hAAAA8001);
    idle(4);
    do_load(2, 32'h40, 3'b010, 32'hCAFEF00D);
    idle(4);
    do_load(0, 32'h03, 3'b001, 32'h000000F0);
    idle(4);
  endtask

  task automatic test_load_random();
    logic [2:0] f3;
    for (int i = 0; i < 24; i++) begin
      f3 = 3'($urandom);
      do_load(i % 2 == 0 ? 0 : 2, $urandom, f3, $urandom);
      idle(4);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) do_load(0, $urandom, 3'($urandom), $urandom);
    idle(4);
    for (int i = 0; i < 3; i++) do_load(2, $urandom, 3'($urandom), $urandom);
    idle(4);
  endtask

  task automatic test_load_priority();
    is_lw = 1'b1; mem_write = 4'hF; func3 = 3'b000; data_addr = 32'h100;
    #1;
    checks++;
    if (web0 !== 4'b0 || en0 !== 1'b1 || stall0 !== 1'b1) begin
      failures++;
      $display("FAIL load_priority web=%b en=%b stall=%b want 0000 1 1", web0, en0, stall0);
    end
    idle(5);
  endtask

  task automatic test_reset_mid_load();
    is_lw = 1'b1; func3 = 3'b010; data_addr = 32'h80; mem_write = 4'b0;
    @(posedge clk); #1;
    is_lw = 1'b0;
    #1;
    checks++;
    if (cnt2 !== 2'd2 || stall2 !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre cnt=%0d stall=%b want 2 1", cnt2, stall2);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (cnt2 !== 2'd0 || stall2 !== 1'b0 || lv2 !== 1'b0 || ld2 !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_post cnt=%0d stall=%b lv=%b ld=%h want 0 0 0 0", cnt2, stall2, lv2, ld2);
    end
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (lv2 !== 1'b0 || stall2 !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid_discard lv=%b stall=%b want 0 0", lv2, stall2);
      end
    end
    do_load(2, 32'h84, 3'b010, 32'h13579BDF);
    idle(4);
  endtask

`ifdef LSU_MISALIGN_TRAP_EN
  task automatic test_misalign();
    rst = 1'b1; idle(1); rst = 1'b0;
    checks++;
    if (mis0 !== 1'b0) begin
      failures++; $display("FAIL mis_reset got=%b want 0", mis0);
    end
    func3 = 3'b010; data_addr = 32'h13; rs2_data = 32'h1; mem_write = 4'hF; is_lw = 1'b0;
    #1;
    checks++;
    if (web0 !== 4'b0) begin
      failures++; $display("FAIL mis_store_web got=%b want 0000", web0);
    end
    idle(4);
    checks++;
    if (mis0 !== 1'b1 || mis2 !== 1'b1) begin
      failures++; $display("FAIL mis_sticky got=%b/%b want 1", mis0, mis2);
    end
    rst = 1'b1; idle(1); rst = 1'b0;
    checks++;
    if (mis0 !== 1'b0) begin
      failures++; $display("FAIL mis_clear got=%b want 0", mis0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_store();
    test_load_directed();
    test_load_random();
    test_back_to_back();
    test_load_priority();
    test_reset_mid_load();
`ifdef LSU_MISALIGN_TRAP_EN
    test_misalign();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store control stage directly downstream of the instruction decoder. It consumes the decoder's isLW, MemWrite lane mask and Func3, plus the ALU-computed data address.
- Sequences the multi-cycle load. It generates counter02, which feeds back to the decoder and gates RegWrite, and a PC stall.
- Drives the synchronous data memory, replicates store data onto byte lanes, and extracts and sign- or zero-extends load data for the register-file write mux.

Parameters:
- MEM_WAIT, 0: extra wait cycles between load request and writeback (legal range 0..3).
- XLEN, 32: data and address width.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- is_lw  input  1  decoder load indication.
- mem_write  input  4  decoder store byte-lane mask; 0 means no store.
- func3  input  3  load/store size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- data_addr  input  XLEN  effective address from ALU.
- rs2_data  input  XLEN  store source register.
- dm_rdata  input  XLEN  data memory read data, valid the cycle after dm_en.
- counter02  output  2  load phase to decoder: 0 = request, 2 = wait, 1 = writeback.
- stall  output  1  hold PC and instruction; high during load request and wait cycles.
- dm_en  output  1  data memory read strobe.
- dm_web  output  4  data memory byte write enables.
- dm_addr  output  XLEN  word address to memory: data_addr with bits [1:0] cleared.
- dm_wdata  output  XLEN  lane-replicated store data.
- load_data  output  XLEN  aligned and extended load result.
- load_valid  output  1  high in the writeback cycle only.

Behaviour:
- Byte-lane order is fixed: offset 0 maps to bits [31:24], offset 1 to [23:16], offset 2 to [15:8], offset 3 to [7:0].
- Reset values: state IDLE, counter02 = 0, stall = 0, dm_en = 0, load_valid = 0, load_data = 0, internal wait counter = 0.
- FSM states are IDLE, LD_REQ, LD_WAIT and LD_WB.
- IDLE, with is_lw = 1:
  - Outputs for this cycle: counter02 = 0, dm_en = 1, stall = 1.
  - Latch addr[1:0] and func3.
  - Next state is LD_WAIT if MEM_WAIT > 0, otherwise LD_WB. The FSM treats this IDLE-with-is_lw cycle as LD_REQ.
- LD_WAIT:
  - Outputs: counter02 = 2, stall = 1, dm_en = 0.
  - Leave for LD_WB after MEM_WAIT cycles, counted by a 2-bit counter that clears on entry.
- LD_WB:
  - Outputs: counter02 = 1, stall = 0, load_valid = 1.
  - load_data is formed combinationally from dm_rdata and the latched offset and func3.
  - Next state is IDLE. A back-to-back load restarts in the following cycle.
- Load extraction:
  - B and BU select byte [31-8*off -: 8].
  - H and HU select [31-8*off -: 16] for off in 0..2.
  - W returns the full word.
  - B and H sign-extend; BU and HU zero-extend.
  - Any other func3 returns dm_rdata unchanged.
- Stores are single-cycle and combinational in IDLE: dm_web = mem_write.
  - dm_wdata is {4{rs2[7:0]}} for SB, {2{rs2[15:0]}} for SH, rs2 for SW.
  - No stall and no state change for stores.
- Simultaneous is_lw and nonzero mem_write: load takes priority and dm_web is forced to 0. This is illegal from the decoder, but the behaviour is defined.
- dm_web is always 0 outside IDLE.
- Reset asserted mid-load: the FSM returns to IDLE next edge with stall = 0 and load_valid = 0. The pending writeback is discarded.
- Inputs are not sampled in LD_WAIT or LD_WB; the latched offset and func3 are used.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- When defined:
  - Adds output misalign (1 bit), a sticky flag cleared only by rst.
  - Sets on a halfword at offset 3, or a word at nonzero offset, for either load or store.
  - A misaligned store forces dm_web = 0.
  - A misaligned load still completes its phases, but load_data = 0.
- When undefined:
  - No port.
  - Misaligned halfword and word accesses use the low address bits as given: a word returns the full word, and a halfword at offset 3 returns bits [7:0] extended.

Decomposition:
- Shared package lsu_pkg holds:
  - func3 size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - the FSM state enum.
  - counter02 phase constants (PH_REQ = 0, PH_WB = 1, PH_WAIT = 2).
- One sub-module, lsu_load_align: combinational lane select and extension. Inputs are rdata, offset and func3; output is load_data. It is reusable for later byte-enable debug ports.

Test Plan:
- SW with addr 0x10, rs2 0xDEADBEEF, mask 1111 -> dm_web = 1111, dm_wdata = 0xDEADBEEF, dm_addr = 0x10, stall = 0.
- LB at addr 0x21 with MEM_WAIT = 0, dm_rdata 0x1280FF34 -> cycle 0: counter02 = 0, stall = 1, dm_en = 1; cycle 1: counter02 = 1, load_valid = 1, load_data = 0xFFFFFF80.
- LHU at addr 0x22, dm_rdata 0xAAAA8001 -> load_data = 0x00008001; LH at the same address -> load_data = 0xFFFF8001.
- MEM_WAIT = 2 LW -> counter02 sequence 0, 2, 2, 1; stall sequence 1, 1, 1, 0; load_data equals dm_rdata.
- Reset asserted during LD_WAIT -> next cycle state IDLE, stall = 0, load_valid = 0. A following LW sequences normally.
- With LSU_MISALIGN_TRAP_EN, SW at addr 0x13 -> dm_web = 0000 and misalign = 1, and it stays 1 until rst.
